// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that shares one FIFO write port among NREQ
//   producers. Each producer uses a valid/ready handshake. The winner is
//   granted for a burst of up to MAX_BURST beats. The FIFO is never written
//   while it reports full. A beat counter per requester is kept for debug.
//
// Ports
//   clk, resetn    clock; asynchronous active-low reset
//   req_valid      per-requester data valid
//   req_data       packed data; requester i occupies bits [i*DW +: DW]
//   req_ready      per-requester accept (at most one bit high)
//   fifo_full      FIFO full flag
//   fifo_wr_enb    FIFO write enable (same cycle as the accepted beat)
//   fifo_wr_data   FIFO write data; holds the last written word when idle
//   grant_id       current or most recent granted requester
//   busy           high while a burst grant is active
//   beat_cnt_sel   selects which requester's beat counter is shown
//   beat_cnt       beats accepted from the selected requester (0 if out of range)
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               fifo_full,
  output logic               fifo_wr_enb,
  output logic [DW-1:0]      fifo_wr_data,
  output logic [2:0]         grant_id,
  output logic               busy,
  input  logic [2:0]         beat_cnt_sel,
  output logic [15:0]        beat_cnt
);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [3:0]    burst_cnt;
  logic [15:0]   beat_cnt_q [NREQ];
  logic [DW-1:0] wr_data_q;
  logic          g_valid;
  logic [DW-1:0] g_data;
  logic [2:0]    winner;
  logic          beat;
  logic          last_beat;

  // Granted lane: valid and data of requester grant_id
  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == 3'(i)) begin
        g_valid = req_valid[i];
        g_data  = req_data[i*DW +: DW];
      end
    end
  end

  // Round-robin search starting at grant_id+1. Offsets are scanned from the
  // farthest to the nearest so the last assignment is the nearest valid one.
  always_comb begin
    winner = grant_id;
    for (int k = NREQ; k >= 1; k--) begin
      for (int j = 0; j < NREQ; j++) begin
        if (req_valid[j] && ((int'(grant_id) + k) % NREQ) == j) begin
          winner = 3'(j);
        end
      end
    end
  end

  assign beat      = (state == BURST) && g_valid && !fifo_full;
  assign last_beat = beat && (burst_cnt == 4'(MAX_BURST - 1));

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // FSM next state. A full FIFO while the granted producer is valid releases
  // the grant so another producer can win once space frees up.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if ((|req_valid) && !fifo_full) state_nxt = BURST;
      BURST:   if (!g_valid || fifo_full || last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: ready and write strobe are combinational from the inputs
  // so a beat reaches the FIFO in the cycle it is accepted.
  always_comb begin
    req_ready    = '0;
    fifo_wr_enb  = 1'b0;
    fifo_wr_data = wr_data_q;
    busy         = 1'b0;
    if (state == BURST) begin
      busy = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (grant_id == 3'(i)) req_ready[i] = !fifo_full;
      end
      if (beat) begin
        fifo_wr_enb  = 1'b1;
        fifo_wr_data = g_data;
      end
    end
  end

  // Grant, burst length and last written word
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_id  <= 3'(NREQ - 1);
      burst_cnt <= '0;
      wr_data_q <= '0;
    end else begin
      if (state == IDLE && state_nxt == BURST) begin
        grant_id  <= winner;
        burst_cnt <= '0;
      end else if (beat) begin
        burst_cnt <= burst_cnt + 4'd1;
      end
      if (beat) wr_data_q <= g_data;
    end
  end

  // Per-requester beat counters, wrapping modulo 2^16
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NREQ; i++) beat_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (beat && grant_id == 3'(i)) beat_cnt_q[i] <= beat_cnt_q[i] + 16'd1;
      end
    end
  end

  always_comb begin
    beat_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (beat_cnt_sel == 3'(i)) beat_cnt = beat_cnt_q[i];
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a behavioural 8-deep FIFO model.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_enb;
  logic [15:0] fifo_wr_data;
  logic [2:0]  grant_id;
  logic        busy;
  logic [2:0]  beat_cnt_sel = '0;
  logic [15:0] beat_cnt;

  int checks = 0;
  int failures = 0;

  logic [15:0] base [4];
  int          sent [4];
  int          limit [4];
  bit          rand_mode = 0;
  int          rd_mode = 0;
  bit          rd_rand = 0;
  bit          pop_one = 0;
  bit          fifo_clr = 1;
  int          fcount = 0;
  bit          ovf = 0;
  logic [15:0] fq[$];
  logic [15:0] rd_log[$];
  logic        rd_en;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NREQ(4), .DW(16), .MAX_BURST(4)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .fifo_full(fifo_full), .fifo_wr_enb(fifo_wr_enb), .fifo_wr_data(fifo_wr_data),
    .grant_id(grant_id), .busy(busy),
    .beat_cnt_sel(beat_cnt_sel), .beat_cnt(beat_cnt)
  );

  // 8-deep FIFO model with reader
  assign fifo_full = (fcount == 8);
  assign rd_en = ((rd_mode == 1) || (rd_mode == 2 && rd_rand) || pop_one) && (fcount > 0);

  always @(posedge clk) begin
    if (fifo_clr) begin
      fq.delete();
      fcount <= 0;
      ovf <= 1'b0;
    end else begin
      if (rd_en) rd_log.push_back(fq.pop_front());
      if (fifo_wr_enb) begin
        if (fcount == 8) ovf <= 1'b1;
        else fq.push_back(fifo_wr_data);
      end
      fcount <= fcount + ((fifo_wr_enb && fcount != 8) ? 1 : 0) - (rd_en ? 1 : 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_data();
    for (int i = 0; i < 4; i++) req_data[i*16 +: 16] = base[i] + 16'(sent[i]);
  endtask

  // One clock: sample handshakes, cross the edge, advance producers.
  task automatic tick();
    logic [3:0] acc;
    acc = req_valid & req_ready;
    check("wr_while_full", 32'(fifo_wr_enb & fifo_full), 0);
    rd_rand = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) begin
        sent[i]++;
        if (sent[i] >= limit[i] || (rand_mode && $urandom_range(0, 3) == 0)) req_valid[i] = 1'b0;
      end else if (rand_mode && !req_valid[i] && sent[i] < limit[i]) begin
        req_valid[i] = ($urandom_range(0, 2) != 0);
      end
    end
    drive_data();
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    fifo_clr = 1'b1;
    req_valid = '0;
    rand_mode = 0;
    rd_mode = 0;
    pop_one = 0;
    for (int i = 0; i < 4; i++) begin
      sent[i] = 0;
      limit[i] = 1000;
      base[i] = '0;
    end
    drive_data();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    fifo_clr = 1'b0;
    #1;
  endtask

  initial begin
    int nexp [4];
    int sum;
    int id;
    logic [15:0] w;
    bit done;

    for (int i = 0; i < 4; i++) begin
      sent[i] = 0;
      limit[i] = 1000;
      base[i] = '0;
    end

    // Reset state
    @(posedge clk);
    #2;
    check("rst_ready", 32'(req_ready), 0);
    check("rst_wr", 32'(fifo_wr_enb), 0);
    check("rst_data", 32'(fifo_wr_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant", 32'(grant_id), 3);
    check("rst_beats", 32'(beat_cnt), 0);

    // Single requester 2, six beats, fast drain
    do_reset();
    rd_mode = 1;
    base[2] = 16'hA000;
    limit[2] = 6;
    drive_data();
    req_valid = 4'b0100;
    #1;
    check("s1_idle_busy", 32'(busy), 0);
    check("s1_idle_ready", 32'(req_ready), 0);
    tick();
    for (int b = 0; b < 4; b++) begin
      check("s1_grant", 32'(grant_id), 2);
      check("s1_ready", 32'(req_ready), 32'h4);
      check("s1_wr", 32'(fifo_wr_enb), 1);
      check("s1_data", 32'(fifo_wr_data), 32'hA000 + b);
      tick();
    end
    check("s1_bubble_busy", 32'(busy), 0);
    check("s1_bubble_wr", 32'(fifo_wr_enb), 0);
    check("s1_bubble_hold", 32'(fifo_wr_data), 32'hA003);
    tick();
    for (int b = 4; b < 6; b++) begin
      check("s1_regrant", 32'(grant_id), 2);
      check("s1_wr2", 32'(fifo_wr_enb), 1);
      check("s1_data2", 32'(fifo_wr_data), 32'hA000 + b);
      tick();
    end
    check("s1_pause_busy", 32'(busy), 1);
    check("s1_pause_wr", 32'(fifo_wr_enb), 0);
    check("s1_pause_hold", 32'(fifo_wr_data), 32'hA005);
    tick();
    check("s1_end_busy", 32'(busy), 0);
    beat_cnt_sel = 3'd2;
    #1;
    check("s1_beat_cnt2", 32'(beat_cnt), 6);

    // All valid, no reads: FIFO fills, full stall, restart after one pop
    do_reset();
    for (int i = 0; i < 4; i++) base[i] = 16'hB000 + 16'(i * 256);
    drive_data();
    req_valid = 4'hF;
    #1;
    check("s2_idle", 32'(busy), 0);
    tick();
    for (int b = 0; b < 4; b++) begin
      check("s2_g0", 32'(grant_id), 0);
      check("s2_g0_data", 32'(fifo_wr_data), 32'hB000 + b);
      tick();
    end
    check("s2_bubble", 32'(busy), 0);
    tick();
    for (int b = 0; b < 4; b++) begin
      check("s2_g1", 32'(grant_id), 1);
      check("s2_g1_data", 32'(fifo_wr_data), 32'hB100 + b);
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      check("s2_full_busy", 32'(busy), 0);
      check("s2_full_ready", 32'(req_ready), 0);
      check("s2_full_grant", 32'(grant_id), 1);
      tick();
    end
    pop_one = 1;
    tick();
    pop_one = 0;
    #1;
    check("s2_after_pop_busy", 32'(busy), 0);
    tick();
    check("s2_regrant", 32'(grant_id), 2);
    check("s2_regrant_wr", 32'(fifo_wr_enb), 1);
    check("s2_regrant_data", 32'(fifo_wr_data), 32'hB200);
    tick();
    check("s2_stall_busy", 32'(busy), 1);
    check("s2_stall_ready", 32'(req_ready), 0);
    check("s2_stall_wr", 32'(fifo_wr_enb), 0);
    tick();
    check("s2_release", 32'(busy), 0);
    check("s2_ovf", 32'(ovf), 0);
    check("s2_fifo_head", 32'(fq[0]), 32'hB001);
    check("s2_fifo_tail", 32'(fq[7]), 32'hB200);
    beat_cnt_sel = 3'd1;
    #1;
    check("s2_beat_cnt1", 32'(beat_cnt), 4);

    // Round-robin order with fast drain
    do_reset();
    rd_mode = 1;
    for (int i = 0; i < 4; i++) base[i] = 16'hC000 + 16'(i * 256);
    drive_data();
    req_valid = 4'hF;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("s3_bubble", 32'(busy), 0);
      tick();
      for (int b = 0; b < 4; b++) begin
        check("s3_grant", 32'(grant_id), k % 4);
        check("s3_wr", 32'(fifo_wr_enb), 1);
        check("s3_data", 32'(fifo_wr_data), 32'(base[k % 4]) + (k / 4) * 4 + b);
        tick();
      end
    end

    // Valid drop mid-burst with requester 0 waiting
    do_reset();
    rd_mode = 1;
    base[3] = 16'hE300;
    base[0] = 16'hE000;
    limit[3] = 2;
    drive_data();
    req_valid = 4'b1000;
    #1;
    tick();
    check("s4_grant3", 32'(grant_id), 3);
    check("s4_data0", 32'(fifo_wr_data), 32'hE300);
    req_valid[0] = 1'b1;
    #1;
    check("s4_ready", 32'(req_ready), 32'h8);
    tick();
    check("s4_data1", 32'(fifo_wr_data), 32'hE301);
    tick();
    check("s4_drop_wr", 32'(fifo_wr_enb), 0);
    tick();
    check("s4_idle", 32'(busy), 0);
    tick();
    check("s4_grant0", 32'(grant_id), 0);
    check("s4_grant0_data", 32'(fifo_wr_data), 32'hE000);

    // Asynchronous reset during the second beat
    do_reset();
    rd_mode = 1;
    base[0] = 16'hD000;
    drive_data();
    req_valid = 4'b0001;
    #1;
    tick();
    check("s5_beat1", 32'(fifo_wr_data), 32'hD000);
    tick();
    check("s5_beat2_wr", 32'(fifo_wr_enb), 1);
    resetn = 1'b0;
    beat_cnt_sel = 3'd0;
    #1;
    check("s5_rst_ready", 32'(req_ready), 0);
    check("s5_rst_wr", 32'(fifo_wr_enb), 0);
    check("s5_rst_grant", 32'(grant_id), 3);
    check("s5_rst_beats", 32'(beat_cnt), 0);
    tick();
    resetn = 1'b1;
    #1;
    check("s5_idle", 32'(busy), 0);
    tick();
    check("s5_grant0", 32'(grant_id), 0);
    check("s5_redo_data", 32'(fifo_wr_data), 32'hD001);

    // Random traffic, random reader: 200 beats end to end
    do_reset();
    rd_log.delete();
    for (int i = 0; i < 4; i++) begin
      base[i] = 16'(i << 12);
      limit[i] = 50;
      nexp[i] = 0;
      req_valid[i] = 1'($urandom_range(0, 1));
    end
    rand_mode = 1;
    rd_mode = 2;
    drive_data();
    #1;
    done = 0;
    for (int c = 0; c < 5000; c++) begin
      if (sent[0] + sent[1] + sent[2] + sent[3] == 200 && fcount == 0) begin
        done = 1;
        break;
      end
      tick();
    end
    check("s6_done", 32'(done), 1);
    check("s6_count", rd_log.size(), 200);
    check("s6_ovf", 32'(ovf), 0);
    for (int j = 0; j < rd_log.size(); j++) begin
      w = rd_log[j];
      id = int'(w[15:12]);
      if (id < 4) begin
        check("s6_order", 32'(w[11:0]), nexp[id]);
        nexp[id]++;
      end else begin
        check("s6_id", id, 0);
      end
    end
    sum = 0;
    for (int s = 0; s < 4; s++) begin
      beat_cnt_sel = 3'(s);
      #1;
      check("s6_beat_cnt", 32'(beat_cnt), 50);
      sum += int'(beat_cnt);
    end
    check("s6_beat_sum", sum, 200);
    for (int s = 4; s < 8; s++) begin
      beat_cnt_sel = 3'(s);
      #1;
      check("s6_sel_oor", 32'(beat_cnt), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
